inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Small synchronous FIFO between the instruction fetch stage (PC register plus instruction memory read) and the decode stage.
- Buffers {pc, instr} pairs so decode can stall without losing fetched instructions.
- Drives pc_enable back to the fetch stage, freezing the PC when the queue is full.
- Discards wrong-path entries on a flush from branch/jump resolution.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
PTR_W, 2, pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  fetch presents a valid {in_pc, in_instr} this cycle
in_pc  input  32  PC of the fetched instruction
in_instr  input  32  instruction word read from instruction memory
flush  input  1  discard all queued entries and the current push (redirect)
out_ready  input  1  decode accepts the head entry this cycle
in_ready  output  1  queue can accept a push this cycle
pc_enable  output  1  to fetch stage PC register write enable
out_valid  output  1  head entry valid
out_pc  output  32  PC of head entry
out_instr  output  32  instruction of head entry
count  output  PTR_W+1  number of occupied entries, 0..DEPTH

Behaviour:
- State:
  - Storage array of DEPTH x 64 bits ({pc, instr}).
  - Registers wr_ptr and rd_ptr, PTR_W bits each; they wrap modulo DEPTH.
  - count register, PTR_W+1 bits.
- Reset (reset=1 at a clock edge):
  - wr_ptr, rd_ptr, count and all storage go to 0.
  - While reset is high: in_ready=0, pc_enable=0, out_valid=0, out_pc=0, out_instr=0.
- Combinational outputs, with reset=0:
  - full = (count==DEPTH). empty = (count==0).
  - in_ready = !full.
  - pc_enable = !full.
  - out_valid = !empty && !flush.
  - out_pc and out_instr = storage[rd_ptr] when out_valid=1, else 0.
- Push and pop:
  - push = in_valid && in_ready && !flush. It writes storage[wr_ptr] and increments wr_ptr.
  - pop = out_valid && out_ready. It increments rd_ptr.
  - No push is accepted when full, even if a pop occurs in the same cycle; in_ready depends on the registered count only.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Neither: unchanged.
- Flush (flush=1, reset=0), taking priority over push and pop:
  - Next cycle: wr_ptr=rd_ptr=count=0.
  - in_instr presented in the flush cycle is dropped.
  - pc_enable follows !full in the flush cycle, so the fetch stage loads the redirect target.
- Latency: without the optional feature, an entry pushed in cycle N is first visible on out_valid in cycle N+1.
- Ordering: strictly FIFO, including across pointer wrap-around.
- Simultaneous reset and flush: reset wins; the result is identical to reset.
- Reset mid-operation: all contents are lost; no partial entry survives.
- Boundary conditions:
  - Full with out_ready=1: the pop proceeds, count becomes DEPTH-1, and in_ready rises the next cycle.
  - Empty with out_ready=1: no effect.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- When defined: if empty, in_valid=1 and flush=0, then:
  - out_valid=1 and out_pc/out_instr=in_pc/in_instr combinationally.
  - If out_ready=1 in that cycle, the entry is consumed directly: no write, pointers and count unchanged.
  - If out_ready=0, the entry is written normally.
- When undefined: no bypass path; minimum push-to-out_valid latency is 1 cycle.

Test Plan:
1. Hold reset 2 cycles with in_valid=1, in_pc=0x100 -> out_valid=0, count=0, in_ready=0, pc_enable=0 throughout; after release, in_ready=1 and pc_enable=1.
2. Push pc 0x0,0x4,0x8,0xC (instr 0xA0..0xA3) with out_ready=0, then attempt a 5th push of pc 0x10 -> count=4, in_ready=pc_enable=0, 5th entry not stored.
3. Drain from the step-2 state with out_ready=1 -> out_pc 0x0,0x4,0x8,0xC and out_instr 0xA0..0xA3 on consecutive cycles; count 3,2,1,0; out_valid=0 when empty.
4. Continuous push and pop for 10 cycles with count held at 2 -> count stays 2, output pcs in push order across pointer wrap (wr_ptr wraps at least twice).
5. count=3 and flush=1 with in_valid=1, in_pc=0x40 -> out_valid=0 in the flush cycle; next cycle count=0 and out_valid=0; 0x40 never appears on out_pc.
6. With IFQ_BYPASS_EN defined: empty, push pc 0x20 with out_ready=1 -> out_valid=1, out_pc=0x20 in the same cycle, count stays 0. Without the macro, the same stimulus -> out_valid=1 only the next cycle, count=1 then 0.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for inst_fetch_queue.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface inst_fetch_queue_if #(
    parameter int PTR_W = 2
);
    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             flush;
    logic             out_ready;
    logic             in_ready;
    logic             pc_enable;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [PTR_W:0]   count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, pc_enable, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, pc_enable, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: FIFO of {pc, instr} pairs between fetch and decode, with flush.
// Optional same-cycle bypass when empty is enabled by defining IFQ_BYPASS_EN.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    inst_fetch_queue_if.slave    bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [63:0]    mem_q [DEPTH];
    logic [63:0]    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic        full;
    logic        empty;
    logic        bypass;
    logic        accept;
    logic        valid;
    logic        push;
    logic        pop;
    logic [63:0] head;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        full   = (count_q == FULL_CNT);
        empty  = (count_q == '0);
`ifdef IFQ_BYPASS_EN
        bypass = !reset && empty && bus.in_valid && !bus.flush;
`else
        bypass = 1'b0;
`endif
        accept = !reset && !full;
        valid  = !reset && ((!empty && !bus.flush) || bypass);

        // A bypassed entry taken by decode in the same cycle never touches storage.
        push   = bus.in_valid && accept && !bus.flush && !(bypass && bus.out_ready);
        pop    = valid && bus.out_ready && !bypass;

        if (bypass)
            head = {bus.in_pc, bus.in_instr};
        else if (valid)
            head = mem_q[rd_ptr_q];
        else
            head = '0;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {bus.in_pc, bus.in_instr};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_d = count_q + (PTR_W+1)'(1);
            else if (pop && !push)
                count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is cleared on reset so no stale instruction word survives a reset.
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign bus.in_ready  = accept;
    assign bus.pc_enable = accept;
    assign bus.out_valid = valid;
    assign bus.out_pc    = head[63:32];
    assign bus.out_instr = head[31:0];
    assign bus.count     = count_q;

endmodule
